btn_pulse_gen: RTL and testbench

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

---
 rtl/btn_pulse_gen.sv | 114 +++++++++++
 tb/tb_btn_pulse_gen.sv | 123 ++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: debounces a raw push-button into a registered level plus a one-cycle toggle-enable pulse.
// Optional auto-repeat while held is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_pulse_gen #(
   parameter int STABLE_CYCLES = 1000,
   parameter int CNT_W         = 16,
   parameter int REPEAT_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic t_pulse,
   output logic stable_level,
   output logic busy
);
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   state_t state_q, state_d;
   logic [1:0] sync_q;
   logic btn_s;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic pulse_q, pulse_d, level_q, level_d, busy_q, busy_d;
   logic rep_pulse;
   if (STABLE_CYCLES < 2 || STABLE_CYCLES > CNT_MAX || REPEAT_CYCLES < 2 || REPEAT_CYCLES > CNT_MAX) begin : g_param_check
      $error("btn_pulse_gen: STABLE_CYCLES/REPEAT_CYCLES outside 2..2^CNT_W-1");
   end
   assign btn_s   = sync_q[1];
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
   logic [CNT_W-1:0] rep_q, rep_d, rep_inc;
   assign rep_inc = (&rep_q) ? rep_q : rep_q + 1'b1;
   // Runs only while the confirmed press is still held; any exit from IDLE_HIGH restarts it.
   always_comb begin
      rep_pulse = (state_q == IDLE_HIGH) && btn_s && (rep_inc >= REPEAT_C);
      rep_d     = ((state_q == IDLE_HIGH) && btn_s && !rep_pulse) ? rep_inc : '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rep_q <= '0;
      else        rep_q <= rep_d;
   end
`else
   assign rep_pulse = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (btn_s) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_HIGH: begin
            if (!btn_s) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_inc >= STABLE_C) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         IDLE_HIGH: begin
            if (!btn_s) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_W'(1);
            end else begin
               pulse_d = rep_pulse;
            end
         end
         WAIT_LOW: begin
            if (btn_s) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_inc >= STABLE_C) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE_LOW;
      endcase
      busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_in};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
         busy_q  <= busy_d;
      end
   end
   assign t_pulse      = pulse_q;
   assign stable_level = level_q;
   assign busy         = busy_q;
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed checks of btn_pulse_gen with STABLE_CYCLES=4, REPEAT_CYCLES=8.
module tb_btn_pulse_gen;
   localparam int S = 4;
   localparam int R = 8;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic btn_in = 1'b1;
   logic t_pulse, stable_level, busy;
   logic tq;
   int passed = 0;
   int fails = 0;
   int total = 0;

   btn_pulse_gen #(.STABLE_CYCLES(S), .CNT_W(16), .REPEAT_CYCLES(R)) dut (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in),
      .t_pulse(t_pulse),
      .stable_level(stable_level),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Downstream toggle flip-flop driven by t_pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) tq <= 1'b0;
      else if (t_pulse) tq <= ~tq;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_pulse"}, t_pulse, 1'b0);
      chk({tag, "_level"}, stable_level, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic check_press(input string tag, input int last);
      btn_in = 1'b1;
      for (int n = 1; n <= last; n++) begin
         tick();
         chk($sformatf("%s_pulse@%0d", tag, n), t_pulse,
             (n == S + 2) || (REP && n > S + 2 && (n - (S + 2)) % R == 0));
         chk($sformatf("%s_busy@%0d", tag, n), busy, n >= 3 && n <= S + 1);
         chk($sformatf("%s_level@%0d", tag, n), stable_level, n >= S + 2);
      end
   endtask

   task automatic check_release(input string tag);
      btn_in = 1'b0;
      for (int n = 1; n <= S + 3; n++) begin
         tick();
         chk($sformatf("%s_pulse@%0d", tag, n), t_pulse, 1'b0);
         chk($sformatf("%s_busy@%0d", tag, n), busy, n >= 3 && n <= S + 1);
         chk($sformatf("%s_level@%0d", tag, n), stable_level, n < S + 2);
      end
   endtask

   initial begin
      logic [13:0] bounce;
      tick();
      tick();
      chk_idle("in_reset");
      reset = 1'b1;
      check_press("hold", 31);
      check_release("release");
      bounce = 14'b00000001110111;
      for (int n = 0; n < 14; n++) begin
         btn_in = bounce[n];
         tick();
         chk($sformatf("bounce_pulse@%0d", n + 1), t_pulse, 1'b0);
         chk($sformatf("bounce_level@%0d", n + 1), stable_level, 1'b0);
      end
      chk("bounce_busy_end", busy, 1'b0);
      btn_in = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         chk($sformatf("abort_busy@%0d", n), busy, n >= 3);
      end
      reset = 1'b0;
      #2;
      chk_idle("async_reset");
      tick();
      chk_idle("held_reset");
      reset = 1'b1;
      check_press("repress", 7);
      check_release("release2");
      reset = 1'b0;
      tick();
      chk("tff_reset", tq, 1'b0);
      reset = 1'b1;
      for (int p = 1; p <= 3; p++) begin
         btn_in = 1'b1;
         repeat (5) tick();
         chk($sformatf("tff_before_%0d", p), tq, p[0] ^ 1'b1);
         repeat (2) tick();
         chk($sformatf("tff_press_%0d", p), tq, p[0]);
         btn_in = 1'b0;
         repeat (7) tick();
         chk($sformatf("tff_release_%0d", p), tq, p[0]);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
